// File: rtl/acc_argmax.sv
// Streaming argmax over NUM_CLASSES signed scores per frame; result one cycle after the last score, held until taken.
// Optional ARGMAX_RELU_EN clamps negative scores to zero before compare and storage.
module acc_argmax #(
  parameter int NUM_CLASSES = 10,
  parameter int DW          = 22,
  parameter int IW          = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [IW-1:0] class_idx,
  output logic [DW-1:0] class_score,
  output logic          busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_DONE
  } state_t;

  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_CLASSES - 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [IW-1:0] r_cnt;
  logic [IW-1:0] w_cnt_nxt;
  logic [IW-1:0] r_best_idx;
  logic [IW-1:0] w_best_idx_nxt;
  logic [DW-1:0] r_best_score;
  logic [DW-1:0] w_best_score_nxt;
  logic [DW-1:0] w_score;
  logic          w_acc;
  logic          w_take;
  logic          w_gt;

`ifdef ARGMAX_RELU_EN
  assign w_score = in_data[DW-1] ? '0 : in_data;
`else
  assign w_score = in_data;
`endif

  // Full-width signed compare: extreme values cannot overflow since no subtraction is done.
  assign w_gt        = $signed(w_score) > $signed(r_best_score);
  assign out_valid   = (r_state == S_DONE);
  assign busy        = (r_state == S_COLLECT);
  assign in_ready    = (r_state != S_DONE) || out_ready;
  assign w_acc       = in_valid && in_ready;
  assign w_take      = out_valid && out_ready;
  assign class_idx   = r_best_idx;
  assign class_score = r_best_score;

  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_best_idx_nxt   = r_best_idx;
    w_best_score_nxt = r_best_score;
    case (r_state)
      S_IDLE: begin
        if (w_acc) begin
          w_state_nxt      = S_COLLECT;
          w_cnt_nxt        = IW'(1);
          w_best_idx_nxt   = '0;
          w_best_score_nxt = w_score;
        end
      end
      S_COLLECT: begin
        if (w_acc) begin
          if (w_gt) begin
            w_best_idx_nxt   = r_cnt;
            w_best_score_nxt = w_score;
          end
          if (r_cnt == LAST_IDX) begin
            w_state_nxt = S_DONE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + IW'(1);
          end
        end
      end
      S_DONE: begin
        // A score arriving with the hand-off becomes index 0 of the next frame.
        if (w_take) begin
          if (w_acc) begin
            w_state_nxt      = S_COLLECT;
            w_cnt_nxt        = IW'(1);
            w_best_idx_nxt   = '0;
            w_best_score_nxt = w_score;
          end else begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_best_idx   <= '0;
      r_best_score <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_best_idx   <= w_best_idx_nxt;
      r_best_score <= w_best_score_nxt;
    end
  end

endmodule
